nn_result_filter: RTL and testbench

//   Downstream of neural_network. On each Ready pulse, snapshots the ten 16-bit

---
 rtl/nn_result_filter_pkg.sv | 11 +
 rtl/nn_result_filter_stability.sv | 65 ++++++
 rtl/nn_result_filter.sv | 100 ++++++++++
 tb/tb_nn_result_filter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/nn_result_filter_pkg.sv
// Shared types and constants for the NN result filter: class count, probability type, scan FSM states.
package nn_result_pkg;
  localparam int NUM_CLASSES = 10;
  localparam int PROB_W      = 16;
  localparam int IDX_W       = $clog2(NUM_CLASSES);
  localparam logic [IDX_W-1:0] DIGIT_NONE = 4'hF;

  typedef logic [PROB_W-1:0] prob_t;

  typedef enum logic [1:0] {IDLE, SCAN, FILTER} state_t;
endpackage

// File: rtl/nn_result_filter_stability.sv
// Candidate/Count tracking: commits a digit once the same argmax is seen STABLE_COUNT times in a row.
module stability_filter
  import nn_result_pkg::*;
#(
  parameter int    STABLE_COUNT = 3,
  parameter prob_t MIN_CONF     = 16'h4000
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic [IDX_W-1:0] i_best,
  input  prob_t            i_m,
  output logic [IDX_W-1:0] o_digit,
  output prob_t            o_conf,
  output logic             o_locked
);
  localparam int CNT_W = (STABLE_COUNT < 2) ? 1 : $clog2(STABLE_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);

  logic [IDX_W-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;
  logic             w_commit;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_hit     = (i_m >= MIN_CONF);
    w_cnt_nxt = '0;
    if (w_hit) begin
      if (i_best == r_cand)
        w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
      else
        w_cnt_nxt = CNT_W'(1);
    end
    w_commit = w_hit && (w_cnt_nxt == CNT_MAX);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cand   <= DIGIT_NONE;
      r_cnt    <= '0;
      o_digit  <= DIGIT_NONE;
      o_conf   <= '0;
      o_locked <= 1'b0;
    end else if (i_clear) begin
      r_cand   <= DIGIT_NONE;
      r_cnt    <= '0;
      o_digit  <= DIGIT_NONE;
      o_conf   <= '0;
      o_locked <= 1'b0;
    end else if (i_en) begin
      r_cnt  <= w_cnt_nxt;
      r_cand <= w_hit ? i_best : DIGIT_NONE;
      // A weak result drops the lock but keeps the last shown digit on the display
      if (!w_hit) begin
        o_locked <= 1'b0;
      end else if (w_commit) begin
        o_digit  <= i_best;
        o_conf   <= i_m;
        o_locked <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/nn_result_filter.sv
// Snapshots class probabilities on Ready, scans for the argmax one class per clock,
// then hands the winner to the stability filter.
module nn_result_filter
  import nn_result_pkg::*;
#(
  parameter int    STABLE_COUNT = 3,
  parameter prob_t MIN_CONF     = 16'h4000
) (
  input  logic                               Clk,
  input  logic                               Reset_n,
  input  logic                               Clear,
  input  logic                               Ready,
  input  logic [NUM_CLASSES-1:0][PROB_W-1:0] Probability,
  output logic [IDX_W-1:0]                   Digit,
  output logic [PROB_W-1:0]                  Confidence,
  output logic                               Locked,
  output logic                               Done,
  output logic                               Busy,
  output logic                               Overrun
);
  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [NUM_CLASSES-1:0][PROB_W-1:0] r_snap;
  logic [IDX_W-1:0]               r_best;
  logic [IDX_W-1:0]               r_idx;
  logic                           r_done;
  logic                           r_overrun;
  logic                           w_accept;
  logic                           w_filt_en;
  logic                           w_scan_last;
  prob_t                          w_m;

  assign w_scan_last = (r_idx == IDX_W'(NUM_CLASSES - 1));
  assign w_m         = r_snap[r_best];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (Ready)       w_state_nxt = SCAN;
      SCAN:    if (w_scan_last) w_state_nxt = FILTER;
      FILTER:                   w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
    if (Clear) w_state_nxt = IDLE;
  end

  always_comb begin
    Busy      = (r_state != IDLE);
    w_accept  = (r_state == IDLE) && Ready && !Clear;
    w_filt_en = (r_state == FILTER) && !Clear;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_snap    <= '0;
      r_best    <= '0;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (Clear) begin
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= (r_state == FILTER);
      if (Ready && Busy) r_overrun <= 1'b1;
      if (w_accept) begin
        r_snap <= Probability;
        r_best <= '0;
        r_idx  <= IDX_W'(1);
      end else if (r_state == SCAN) begin
        // strict compare keeps the lowest index on ties
        if (r_snap[r_idx] > r_snap[r_best]) r_best <= r_idx;
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign Done    = r_done;
  assign Overrun = r_overrun;

  stability_filter #(
    .STABLE_COUNT(STABLE_COUNT),
    .MIN_CONF    (MIN_CONF)
  ) u_filt (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_en    (w_filt_en),
    .i_clear (Clear),
    .i_best  (r_best),
    .i_m     (w_m),
    .o_digit (Digit),
    .o_conf  (Confidence),
    .o_locked(Locked)
  );
endmodule

// File: tb/tb_nn_result_filter.sv
// Randomized and directed bench for nn_result_filter against a transaction-level reference model.
module tb_nn_result_filter;
  logic                  Clk = 1'b0;
  logic                  Reset_n = 1'b1;
  logic                  Clear = 1'b0;
  logic                  Ready = 1'b0;
  logic [9:0][15:0]      Probability = '0;
  logic [3:0]            Digit;
  logic [15:0]           Confidence;
  logic                  Locked, Done, Busy, Overrun;

  int n_chk = 0;
  int n_pass = 0;

  nn_result_filter dut (
    .Clk(Clk), .Reset_n(Reset_n), .Clear(Clear), .Ready(Ready),
    .Probability(Probability), .Digit(Digit), .Confidence(Confidence),
    .Locked(Locked), .Done(Done), .Busy(Busy), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a result becomes visible 10 edges after acceptance
  int          m_timer = 0;
  int          m_cand = 15, m_cnt = 0, m_best = 0;
  logic [15:0] m_max = 0;
  logic [3:0]  m_digit = 4'hF;
  logic [15:0] m_conf = 0;
  bit          m_locked = 0, m_done = 0, m_ovr = 0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_timer = 0; m_cand = 15; m_cnt = 0; m_digit = 4'hF; m_conf = 0;
      m_locked = 0; m_done = 0; m_ovr = 0;
    end else if (Clear) begin
      m_timer = 0; m_cand = 15; m_cnt = 0; m_digit = 4'hF; m_conf = 0;
      m_locked = 0; m_done = 0; m_ovr = 0;
    end else begin
      m_done = 0;
      if (m_timer > 0) begin
        if (Ready) m_ovr = 1;
        m_timer--;
        if (m_timer == 0) begin
          m_done = 1;
          if (m_max < 16'h4000) begin
            m_cnt = 0; m_cand = 15; m_locked = 0;
          end else begin
            if (m_best == m_cand) m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
            else begin m_cand = m_best; m_cnt = 1; end
            if (m_cnt == 3) begin
              m_digit = 4'(m_best); m_conf = m_max; m_locked = 1;
            end
          end
        end
      end else if (Ready) begin
        m_best = 0;
        for (int i = 1; i < 10; i++) if (Probability[i] > Probability[m_best]) m_best = i;
        m_max = Probability[m_best];
        m_timer = 10;
      end
    end
  end

  always @(negedge Clk) begin
    chk("digit", Digit, m_digit);
    chk("conf", Confidence, m_conf);
    chk("locked", Locked, m_locked);
    chk("done", Done, m_done);
    chk("busy", Busy, m_timer > 0);
    chk("overrun", Overrun, m_ovr);
  end

  task automatic tick();
    @(posedge Clk); #2;
  endtask

  function automatic logic [9:0][15:0] pat(input int a, input logic [15:0] va,
                                            input int b, input logic [15:0] vb);
    logic [9:0][15:0] p;
    for (int i = 0; i < 10; i++) p[i] = 16'h0100;
    p[b] = vb;
    p[a] = va;
    return p;
  endfunction

  task automatic pulse(input logic [9:0][15:0] p);
    Probability = p; Ready = 1'b1; tick(); Ready = 1'b0;
  endtask

  task automatic send(input logic [9:0][15:0] p);
    pulse(p); repeat (11) tick();
  endtask

  int dones;

  initial begin
    #1 Reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_digit", Digit, 4'hF);
    chk("rst_locked", Locked, 0);
    chk("rst_busy", Busy, 0);
    Reset_n = 1'b1;
    tick();

    // 1: three strong 7s commit on the third
    send(pat(7, 16'h9000, 0, 16'h0100)); chk("t1_lock1", Locked, 0);
    send(pat(7, 16'h9000, 0, 16'h0100)); chk("t1_lock2", Locked, 0);
    send(pat(7, 16'h9000, 0, 16'h0100));
    chk("t1_digit", Digit, 7); chk("t1_conf", Confidence, 16'h9000); chk("t1_lock3", Locked, 1);

    // 2: tie resolves to lowest index
    repeat (3) send(pat(2, 16'h8000, 5, 16'h8000));
    chk("t2_digit", Digit, 2);

    // 3: lock 7, one stray 3, two 7s keep 7 shown
    repeat (3) send(pat(7, 16'h9000, 0, 16'h0100));
    send(pat(3, 16'h9000, 0, 16'h0100)); chk("t3_hold3", Digit, 7);
    repeat (2) send(pat(7, 16'hA000, 0, 16'h0100));
    chk("t3_hold7", Digit, 7); chk("t3_conf_hold", Confidence, 16'h9000);
    send(pat(7, 16'hB000, 0, 16'h0100)); chk("t3_recommit", Confidence, 16'hB000);
    send(pat(7, 16'hC000, 0, 16'h0100)); chk("t3_sat", Confidence, 16'hC000);

    // 4: weak result unlocks, digit holds; three 4s take over
    send(pat(7, 16'h3FFF, 0, 16'h0100));
    chk("t4_unlock", Locked, 0); chk("t4_digit", Digit, 7);
    repeat (3) send(pat(4, 16'h5000, 0, 16'h0100));
    chk("t4_digit4", Digit, 4); chk("t4_lock", Locked, 1);

    // 5: second Ready mid-scan is an overrun, only one Done
    pulse(pat(1, 16'h7000, 0, 16'h0100));
    repeat (3) tick();
    Ready = 1'b1; tick(); Ready = 1'b0;
    dones = 0;
    repeat (10) begin tick(); if (Done) dones++; end
    chk("t5_dones", dones, 1); chk("t5_ovr", Overrun, 1);
    Clear = 1'b1; Ready = 1'b1; tick(); Clear = 1'b0; Ready = 1'b0;
    chk("t5_ovr_clr", Overrun, 0); chk("t5_digit", Digit, 4'hF); chk("t5_busy", Busy, 0);

    // 6: reset mid-scan leaves nothing behind
    repeat (2) send(pat(6, 16'h9000, 0, 16'h0100));
    pulse(pat(6, 16'h9000, 0, 16'h0100));
    repeat (4) tick();
    Reset_n = 1'b0;
    dones = 0;
    repeat (8) begin tick(); if (Done) dones++; end
    chk("t6_nodone", dones, 0); chk("t6_busy", Busy, 0);
    Reset_n = 1'b1; tick();
    pulse(pat(6, 16'h9000, 0, 16'h0100));
    dones = 0;
    repeat (10) begin if (Done) dones++; tick(); end
    chk("t6_done_lat", Done, 1); chk("t6_dones", dones + int'(Done), 1);
    repeat (2) tick();

    // random traffic with a small winner set so commits happen
    for (int it = 0; it < 3000; it++) begin
      for (int i = 0; i < 10; i++) Probability[i] = 16'($urandom_range(0, 16'h4800));
      if ($urandom_range(0, 4) != 0) begin
        int w;
        w = ($urandom_range(0, 2) == 0) ? 8 : 3;
        Probability[w] = 16'($urandom_range(16'h4800, 16'hFFFF));
        if ($urandom_range(0, 7) == 0) Probability[w == 8 ? 1 : 5] = Probability[w];
      end
      Ready   = ($urandom_range(0, 6) == 0);
      Clear   = ($urandom_range(0, 150) == 0);
      if ($urandom_range(0, 400) == 0) Reset_n = 1'b0;
      else Reset_n = 1'b1;
      tick();
    end
    Ready = 1'b0; Clear = 1'b0; Reset_n = 1'b1;
    repeat (12) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
